// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one combinational ALU between two requesters.
//   Picks a winner (round-robin, or port 0 first when FIXED_PRI=1), registers its
//   operands onto the ALU inputs, captures the ALU outputs one cycle later, and
//   holds the response for the granted port until that port accepts it.
//   Illegal ops (op=11 with sign=0) skip the ALU and respond with rsp_err=1.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   i_rN_req_valid/o_rN_req_ready request handshake, port N = 0,1
//   i_rN_ope1/ope2/op/sign        request operands, op 00 add 01 sub 10 or 11 slt
//   o_rN_rsp_valid/i_rN_rsp_ready response handshake
//   o_rsp_result/zero/ovf/err     shared response data, qualified by o_rN_rsp_valid
//   o_alu_ope1/ope2/op/sign       registered ALU inputs
//   i_alu_result/zero/ovf         ALU outputs
//   o_busy                        an operation is in progress
module alu_req_arbiter #(
    parameter int DATA_W    = 32,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_r0_req_valid,
    output logic              o_r0_req_ready,
    input  logic [DATA_W-1:0] i_r0_ope1,
    input  logic [DATA_W-1:0] i_r0_ope2,
    input  logic [1:0]        i_r0_op,
    input  logic              i_r0_sign,
    output logic              o_r0_rsp_valid,
    input  logic              i_r0_rsp_ready,
    input  logic              i_r1_req_valid,
    output logic              o_r1_req_ready,
    input  logic [DATA_W-1:0] i_r1_ope1,
    input  logic [DATA_W-1:0] i_r1_ope2,
    input  logic [1:0]        i_r1_op,
    input  logic              i_r1_sign,
    output logic              o_r1_rsp_valid,
    input  logic              i_r1_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_result,
    output logic              o_rsp_zero,
    output logic              o_rsp_ovf,
    output logic              o_rsp_err,
    output logic [DATA_W-1:0] o_alu_ope1,
    output logic [DATA_W-1:0] o_alu_ope2,
    output logic [1:0]        o_alu_op,
    output logic              o_alu_sign,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_alu_zero,
    input  logic              i_alu_ovf,
    output logic              o_busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t            r_state, w_next;
    logic              r_rr_ptr, r_gnt;
    logic [DATA_W-1:0] r_alu_ope1, r_alu_ope2, r_rsp_result;
    logic [1:0]        r_alu_op;
    logic              r_alu_sign, r_rsp_zero, r_rsp_ovf, r_rsp_err;
    logic              w_pick1, w_accept, w_illegal, w_rsp_ready, w_done, w_sign;
    logic [DATA_W-1:0] w_ope1, w_ope2;
    logic [1:0]        w_op;
    always_comb begin
        // port 1 wins when alone, or on a tie when the round-robin pointer favours it
        w_pick1     = i_r1_req_valid & (~i_r0_req_valid | (!FIXED_PRI & r_rr_ptr));
        w_accept    = (r_state == IDLE) & (i_r0_req_valid | i_r1_req_valid);
        w_ope1      = w_pick1 ? i_r1_ope1 : i_r0_ope1;
        w_ope2      = w_pick1 ? i_r1_ope2 : i_r0_ope2;
        w_op        = w_pick1 ? i_r1_op   : i_r0_op;
        w_sign      = w_pick1 ? i_r1_sign : i_r0_sign;
        w_illegal   = (w_op == 2'b11) & ~w_sign;
        w_rsp_ready = r_gnt ? i_r1_rsp_ready : i_r0_rsp_ready;
        w_done      = (r_state == RESP) & w_rsp_ready;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? (w_illegal ? RESP : EXEC) : IDLE;
            EXEC:    w_next = RESP;
            RESP:    w_next = w_rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        // ready is forced low while reset is asserted so every output reads 0
        o_r0_req_ready = rst_n & w_accept & ~w_pick1;
        o_r1_req_ready = rst_n & w_accept & w_pick1;
        o_r0_rsp_valid = (r_state == RESP) & ~r_gnt;
        o_r1_rsp_valid = (r_state == RESP) & r_gnt;
        o_busy         = r_state != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= 1'b0;
            r_gnt        <= 1'b0;
            r_alu_ope1   <= '0;
            r_alu_ope2   <= '0;
            r_alu_op     <= '0;
            r_alu_sign   <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_ovf    <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_gnt <= w_pick1;
                // illegal ops never reach the ALU; its inputs keep their previous value
                if (w_illegal) begin
                    r_rsp_result <= '0;
                    r_rsp_zero   <= 1'b0;
                    r_rsp_ovf    <= 1'b0;
                    r_rsp_err    <= 1'b1;
                end else begin
                    r_alu_ope1 <= w_ope1;
                    r_alu_ope2 <= w_ope2;
                    r_alu_op   <= w_op;
                    r_alu_sign <= w_sign;
                end
            end
            if (r_state == EXEC) begin
                r_rsp_result <= i_alu_result;
                r_rsp_zero   <= i_alu_zero;
                // overflow is only meaningful for a signed add
                r_rsp_ovf    <= i_alu_ovf & (r_alu_op == 2'b00) & r_alu_sign;
                r_rsp_err    <= 1'b0;
            end
            if (w_done) r_rr_ptr <= ~r_gnt;
        end
    end
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_zero   = r_rsp_zero;
    assign o_rsp_ovf    = r_rsp_ovf;
    assign o_rsp_err    = r_rsp_err;
    assign o_alu_ope1   = r_alu_ope1;
    assign o_alu_ope2   = r_alu_ope2;
    assign o_alu_op     = r_alu_op;
    assign o_alu_sign   = r_alu_sign;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed and randomized checks of alu_req_arbiter against a transaction-level model.
module tb_alu_req_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        i_r0_req_valid = 0, i_r1_req_valid = 0, i_r0_sign = 0, i_r1_sign = 0;
    logic        i_r0_rsp_ready = 1, i_r1_rsp_ready = 1;
    logic [31:0] i_r0_ope1 = 0, i_r0_ope2 = 0, i_r1_ope1 = 0, i_r1_ope2 = 0;
    logic [1:0]  i_r0_op = 0, i_r1_op = 0;
    logic        o_r0_req_ready, o_r1_req_ready, o_r0_rsp_valid, o_r1_rsp_valid;
    logic [31:0] o_rsp_result, o_alu_ope1, o_alu_ope2, i_alu_result;
    logic        o_rsp_zero, o_rsp_ovf, o_rsp_err, o_alu_sign, i_alu_zero, i_alu_ovf, o_busy;
    logic [1:0]  o_alu_op;
    logic [32:0] alu_out;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    alu_req_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_r0_req_valid(i_r0_req_valid), .o_r0_req_ready(o_r0_req_ready),
        .i_r0_ope1(i_r0_ope1), .i_r0_ope2(i_r0_ope2), .i_r0_op(i_r0_op), .i_r0_sign(i_r0_sign),
        .o_r0_rsp_valid(o_r0_rsp_valid), .i_r0_rsp_ready(i_r0_rsp_ready),
        .i_r1_req_valid(i_r1_req_valid), .o_r1_req_ready(o_r1_req_ready),
        .i_r1_ope1(i_r1_ope1), .i_r1_ope2(i_r1_ope2), .i_r1_op(i_r1_op), .i_r1_sign(i_r1_sign),
        .o_r1_rsp_valid(o_r1_rsp_valid), .i_r1_rsp_ready(i_r1_rsp_ready),
        .o_rsp_result(o_rsp_result), .o_rsp_zero(o_rsp_zero), .o_rsp_ovf(o_rsp_ovf), .o_rsp_err(o_rsp_err),
        .o_alu_ope1(o_alu_ope1), .o_alu_ope2(o_alu_ope2), .o_alu_op(o_alu_op), .o_alu_sign(o_alu_sign),
        .i_alu_result(i_alu_result), .i_alu_zero(i_alu_zero), .i_alu_ovf(i_alu_ovf),
        .o_busy(o_busy)
    );

    // ALU: {raw overflow, result}; raw overflow also reported for sub and unsigned ops
    function automatic logic [32:0] alu_f(input logic [31:0] a, b, input logic [1:0] op, input logic s);
        logic [31:0] r;
        logic        v;
        case (op)
            2'd0: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            2'd1: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            2'd2: begin r = a | b; v = 1'b0; end
            default: begin r = s ? {31'b0, $signed(a) < $signed(b)} : {31'b0, a < b}; v = 1'b0; end
        endcase
        return {v, r};
    endfunction

    always_comb alu_out = alu_f(o_alu_ope1, o_alu_ope2, o_alu_op, o_alu_sign);
    assign i_alu_result = alu_out[31:0];
    assign i_alu_zero   = alu_out[31:0] == 32'd0;
    assign i_alu_ovf    = alu_out[32];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Transaction model: one outstanding op, its age in cycles since acceptance,
    // and the response it owes once old enough.
    logic        m_pend, m_port, m_rr, m_err, m_zero, m_ovf, m_s;
    logic [31:0] m_res, m_a1, m_a2;
    logic [1:0]  m_op;
    int          m_age;
    wire         m_w1  = i_r1_req_valid && (!i_r0_req_valid || m_rr);
    wire  [31:0] s_a   = m_w1 ? i_r1_ope1 : i_r0_ope1;
    wire  [31:0] s_b   = m_w1 ? i_r1_ope2 : i_r0_ope2;
    wire  [1:0]  s_op  = m_w1 ? i_r1_op : i_r0_op;
    wire         s_s   = m_w1 ? i_r1_sign : i_r0_sign;
    wire         s_ill = (s_op == 2'b11) && !s_s;
    wire  [32:0] s_f   = alu_f(s_a, s_b, s_op, s_s);
    wire         e_valid = m_pend && (m_age >= (m_err ? 1 : 2));
    wire         e_rdy0  = !m_pend && i_r0_req_valid && !m_w1;
    wire         e_rdy1  = !m_pend && m_w1;
    wire         e_ack   = m_port ? i_r1_rsp_ready : i_r0_rsp_ready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 0; m_port <= 0; m_rr <= 0; m_err <= 0; m_zero <= 0; m_ovf <= 0;
            m_res <= 0; m_a1 <= 0; m_a2 <= 0; m_op <= 0; m_s <= 0; m_age <= 0;
        end else if (!m_pend) begin
            if (i_r0_req_valid || i_r1_req_valid) begin
                m_pend <= 1;
                m_port <= m_w1;
                m_age  <= 1;
                m_err  <= s_ill;
                m_res  <= s_ill ? 32'd0 : s_f[31:0];
                m_zero <= !s_ill && (s_f[31:0] == 32'd0);
                m_ovf  <= !s_ill && s_f[32] && (s_op == 2'd0) && s_s;
                if (!s_ill) begin
                    m_a1 <= s_a; m_a2 <= s_b; m_op <= s_op; m_s <= s_s;
                end
            end
        end else if (e_valid && e_ack) begin
            m_pend <= 0;
            m_rr   <= !m_port;
        end else if (m_age < 3) begin
            m_age <= m_age + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_ready0", o_r0_req_ready, e_rdy0);
            chk("req_ready1", o_r1_req_ready, e_rdy1);
            chk("rsp_valid0", o_r0_rsp_valid, e_valid && !m_port);
            chk("rsp_valid1", o_r1_rsp_valid, e_valid && m_port);
            chk("busy", o_busy, m_pend);
            chk("alu_ope1", o_alu_ope1, m_a1);
            chk("alu_ope2", o_alu_ope2, m_a2);
            chk("alu_op_sign", {o_alu_op, o_alu_sign}, {m_op, m_s});
            if (e_valid) begin
                chk("rsp_result", o_rsp_result, m_res);
                chk("rsp_zero", o_rsp_zero, m_zero);
                chk("rsp_ovf", o_rsp_ovf, m_ovf);
                chk("rsp_err", o_rsp_err, m_err);
            end
        end
    end

    task automatic set_req(input int p, input logic v, input logic [31:0] a, b, input logic [1:0] op, input logic s);
        if (p == 0) begin
            i_r0_req_valid = v; i_r0_ope1 = a; i_r0_ope2 = b; i_r0_op = op; i_r0_sign = s;
        end else begin
            i_r1_req_valid = v; i_r1_ope1 = a; i_r1_ope2 = b; i_r1_op = op; i_r1_sign = s;
        end
    endtask

    task automatic set_valid(input int p, input logic v);
        if (p == 0) i_r0_req_valid = v;
        else        i_r1_req_valid = v;
    endtask

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return $urandom_range(0, 5);
            2: return 32'h7FFF_FFFF;
            default: return ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
        endcase
    endfunction

    // single op on port p with literal expectations; lat counts cycles from the accept cycle
    task automatic op_check(input int p, input logic [31:0] a, b, input logic [1:0] op, input logic s,
                            input logic [31:0] er, input logic ez, eo, ee, input int elat, input string nm);
        int          n;
        logic [31:0] pa1;
        logic [2:0]  pos;
        @(posedge clk); #1;
        i_r0_req_valid = 0; i_r1_req_valid = 0; i_r0_rsp_ready = 1; i_r1_rsp_ready = 1;
        set_req(p, 1, a, b, op, s);
        n = 0;
        @(negedge clk);
        while (!(p != 0 ? o_r1_req_ready : o_r0_req_ready) && n < 20) begin n++; @(negedge clk); end
        chk({nm, "_accept_timeout"}, n < 20, 1);
        pa1 = o_alu_ope1;
        pos = {o_alu_op, o_alu_sign};
        @(posedge clk); #1;
        set_valid(p, 0);
        n = 1;
        @(negedge clk);
        while (!(p != 0 ? o_r1_rsp_valid : o_r0_rsp_valid) && n < 20) begin n++; @(negedge clk); end
        chk({nm, "_latency"}, n, elat);
        chk({nm, "_result"}, o_rsp_result, er);
        chk({nm, "_zero"}, o_rsp_zero, ez);
        chk({nm, "_ovf"}, o_rsp_ovf, eo);
        chk({nm, "_err"}, o_rsp_err, ee);
        if (ee) begin
            chk({nm, "_alu_ope1_kept"}, o_alu_ope1, pa1);
            chk({nm, "_alu_op_kept"}, {o_alu_op, o_alu_sign}, pos);
        end
    endtask

    task automatic rnd_port(input int p, input logic acc);
        logic v;
        v = (p != 0) ? i_r1_req_valid : i_r0_req_valid;
        if (v && (acc || $urandom_range(0, 19) == 0)) set_valid(p, 0);
        else if (!v && $urandom_range(0, 2) == 0)
            set_req(p, 1, rv(), rv(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        int   n;
        int   gp[$], gc[$];
        logic acc0, acc1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", o_busy, 0);
        chk("reset_alu_ope1", o_alu_ope1, 0);
        chk("reset_result", o_rsp_result, 0);
        chk("reset_rsp_valid", {o_r0_rsp_valid, o_r1_rsp_valid}, 0);

        // both ports valid continuously from reset: alternating grants every 3 cycles
        @(posedge clk); #1;
        rst_n = 1;
        set_req(0, 1, 32'd1, 32'd1, 2'd0, 1'b0);
        set_req(1, 1, 32'd2, 32'd2, 2'd0, 1'b0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (o_r0_req_ready) begin gp.push_back(0); gc.push_back(c); end
            if (o_r1_req_ready) begin gp.push_back(1); gc.push_back(c); end
        end
        chk("rr_grant_count", gp.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("rr_grant_port", (k < gp.size()) ? gp[k] : 9, k % 2);
            chk("rr_grant_cycle", (k < gc.size()) ? gc[k] : 99, 3 * k);
        end
        @(posedge clk); #1;
        i_r0_req_valid = 0; i_r1_req_valid = 0;

        op_check(0, 32'd7, 32'hFFFF_FFFD, 2'd0, 1'b1, 32'd4, 0, 0, 0, 2, "add_neg");
        op_check(0, 32'h7FFF_FFFF, 32'd1, 2'd0, 1'b1, 32'h8000_0000, 0, 1, 0, 2, "add_ovf_signed");
        op_check(0, 32'h7FFF_FFFF, 32'd1, 2'd0, 1'b0, 32'h8000_0000, 0, 0, 0, 2, "add_ovf_unsigned");
        op_check(0, 32'd5, 32'd5, 2'd1, 1'b1, 32'd0, 1, 0, 0, 2, "sub_zero");
        op_check(1, 32'h8000_0000, 32'd1, 2'd1, 1'b1, 32'h7FFF_FFFF, 0, 0, 0, 2, "sub_ovf_masked");
        op_check(1, 32'd9, 32'd9, 2'd3, 1'b0, 32'd0, 0, 0, 1, 1, "illegal");
        op_check(1, 32'hFFFF_FFFF, 32'd2, 2'd3, 1'b1, 32'd1, 0, 0, 0, 2, "slt_signed");

        // response backpressure on port 0 while port 1 waits
        @(posedge clk); #1;
        i_r0_rsp_ready = 0; i_r1_rsp_ready = 1;
        set_req(0, 1, 32'd3, 32'd4, 2'd0, 1'b1);
        set_req(1, 1, 32'd1, 32'd2, 2'd2, 1'b0);
        n = 0;
        @(negedge clk);
        while (!o_r0_req_ready && n < 20) begin n++; @(negedge clk); end
        chk("bp_accept_timeout", n < 20, 1);
        @(posedge clk); #1;
        set_valid(0, 0);
        n = 0;
        @(negedge clk);
        while (!o_r0_rsp_valid && n < 20) begin n++; @(negedge clk); end
        chk("bp_rsp_timeout", n < 20, 1);
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(negedge clk);
            chk("bp_result_stable", o_rsp_result, 32'd7);
            chk("bp_rsp_valid0", o_r0_rsp_valid, 1);
            chk("bp_r1_ready", o_r1_req_ready, 0);
            chk("bp_busy", o_busy, 1);
        end
        @(posedge clk); #1;
        i_r0_rsp_ready = 1;
        @(negedge clk);
        chk("bp_exit_r1_ready", o_r1_req_ready, 0);
        @(negedge clk);
        chk("bp_release_r1_ready", o_r1_req_ready, 1);
        @(posedge clk); #1;
        set_valid(1, 0);
        n = 0;
        @(negedge clk);
        while (!o_r1_rsp_valid && n < 20) begin n++; @(negedge clk); end
        chk("bp_r1_result", o_rsp_result, 32'd3);

        // reset during EXEC of a port 1 op, with the pointer favouring port 1
        op_check(0, 32'd10, 32'd20, 2'd0, 1'b0, 32'd30, 0, 0, 0, 2, "pre_reset");
        @(posedge clk); #1;
        set_req(1, 1, 32'd5, 32'd6, 2'd0, 1'b1);
        n = 0;
        @(negedge clk);
        while (!o_r1_req_ready && n < 20) begin n++; @(negedge clk); end
        chk("rst_accept_timeout", n < 20, 1);
        @(posedge clk); #2;
        rst_n = 0;
        set_req(0, 1, 32'd1, 32'd1, 2'd0, 1'b0);
        set_req(1, 1, 32'd2, 32'd2, 2'd0, 1'b0);
        #1;
        chk("rst_req_ready", {o_r0_req_ready, o_r1_req_ready}, 0);
        chk("rst_rsp_valid", {o_r0_rsp_valid, o_r1_rsp_valid}, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_alu_ope1", o_alu_ope1, 0);
        chk("rst_alu_ope2", o_alu_ope2, 0);
        chk("rst_alu_op_sign", {o_alu_op, o_alu_sign}, 0);
        chk("rst_rsp_fields", {o_rsp_result, o_rsp_zero, o_rsp_ovf, o_rsp_err}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        @(negedge clk);
        chk("rst_tie_r0", o_r0_req_ready, 1);
        chk("rst_tie_r1", o_r1_req_ready, 0);
        @(posedge clk); #1;
        i_r0_req_valid = 0; i_r1_req_valid = 0;
        repeat (4) @(posedge clk);

        // randomized traffic checked by the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc0 = o_r0_req_ready;
            acc1 = o_r1_req_ready;
            @(posedge clk); #1;
            rnd_port(0, acc0);
            rnd_port(1, acc1);
            i_r0_rsp_ready = $urandom_range(0, 3) != 0;
            i_r1_rsp_ready = $urandom_range(0, 3) != 0;
        end
        @(posedge clk); #1;
        i_r0_req_valid = 0; i_r1_req_valid = 0; i_r0_rsp_ready = 1; i_r1_rsp_ready = 1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("final_idle", o_busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
